// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: opcodes, response codes,
// FSM states and the packed command record carried through the FIFO.
package apb_seq_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_POLL    = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_POLL    = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_POLL_WAIT,
        S_RESP
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_DATA_W-1:0] mask;
    } cmd_t;

    function automatic logic poll_match(
        input logic [CMD_DATA_W-1:0] rdata,
        input logic [CMD_DATA_W-1:0] expv,
        input logic [CMD_DATA_W-1:0] mask
    );
        return ((rdata ^ expv) & mask) == '0;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO holding queued commands.
// Ports: push/din in, pop/dout (head) out, full/empty flags.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer bit tells full from empty when indices match.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// APB master executing queued WRITE/READ/POLL commands with wait-state
// timeout and per-command responses.
// Ports: cmd_* (command in), rsp_* (response out), busy, APB master.
module apb_cmd_sequencer
    import apb_seq_pkg::*;
#(
    parameter int ADDR_W      = CMD_ADDR_W,
    parameter int DATA_W      = CMD_DATA_W,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int POLL_MAX    = 1024,
    parameter int POLL_GAP    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [PW-1:0] PM_LAST  = PW'(POLL_MAX - 1);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_e            state;
    state_e            state_d;
    cmd_t              cmd_in;
    cmd_t              head;
    cmd_t              cmd_q;
    logic              full;
    logic              empty;
    logic              pop;
    logic              rsp_ld;
    err_e              err_d;
    err_e              err_q;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              wait_clr;
    logic              wait_inc;
    logic              att_inc;
    logic              gap_clr;
    logic              gap_inc;
    logic [TW-1:0]     wait_cnt;
    logic [PW-1:0]     att_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              hit;

    always_comb begin
        cmd_in.op    = op_e'(cmd_op);
        cmd_in.addr  = cmd_addr;
        cmd_in.wdata = cmd_wdata;
        cmd_in.mask  = cmd_mask;
    end

    apb_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign cmd_ready = !full;
    assign rsp_valid = (state == S_RESP);
    assign rsp_op    = cmd_q.op;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = !empty || (state != S_IDLE);
    assign hit       = poll_match(PRDATA, cmd_q.wdata, cmd_q.mask);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d  = state;
        pop      = 1'b0;
        rsp_ld   = 1'b0;
        err_d    = ERR_OK;
        rdata_d  = '0;
        wait_clr = 1'b0;
        wait_inc = 1'b0;
        att_inc  = 1'b0;
        gap_clr  = 1'b0;
        gap_inc  = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PADDR    = '0;
        PWRITE   = 1'b0;
        PWDATA   = '0;

        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.op == OP_ILLEGAL) begin
                        rsp_ld = 1'b1;
                        err_d  = ERR_ILLEGAL;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                PSEL     = 1'b1;
                PADDR    = cmd_q.addr;
                PWRITE   = (cmd_q.op == OP_WRITE);
                PWDATA   = PWRITE ? cmd_q.wdata : '0;
                wait_clr = 1'b1;
                state_d  = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PADDR   = cmd_q.addr;
                PWRITE  = (cmd_q.op == OP_WRITE);
                PWDATA  = PWRITE ? cmd_q.wdata : '0;
                // A completing edge takes priority over the timeout.
                if (PREADY) begin
                    unique case (cmd_q.op)
                        OP_POLL: begin
                            if (hit) begin
                                rsp_ld  = 1'b1;
                                rdata_d = PRDATA;
                            end else if (att_cnt == PM_LAST) begin
                                rsp_ld  = 1'b1;
                                err_d   = ERR_POLL;
                                rdata_d = PRDATA;
                            end else begin
                                att_inc = 1'b1;
                                if (POLL_GAP > 0) begin
                                    gap_clr = 1'b1;
                                    state_d = S_POLL_WAIT;
                                end else begin
                                    state_d = S_SETUP;
                                end
                            end
                        end
                        OP_READ: begin
                            rsp_ld  = 1'b1;
                            rdata_d = PRDATA;
                        end
                        default: rsp_ld = 1'b1;
                    endcase
                end else if (TIMEOUT_CYC > 0 && wait_cnt == TO_LAST) begin
                    rsp_ld = 1'b1;
                    err_d  = ERR_TIMEOUT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_POLL_WAIT: begin
                if (gap_cnt == GAP_LAST) state_d = S_SETUP;
                else                     gap_inc = 1'b1;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rsp_ld) state_d = S_RESP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            err_q    <= ERR_OK;
            rdata_q  <= '0;
            wait_cnt <= '0;
            att_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            if (pop) cmd_q <= head;
            if (rsp_ld) begin
                err_q   <= err_d;
                rdata_q <= rdata_d;
            end
            if (wait_clr)      wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + TW'(1);
            if (pop)          att_cnt <= '0;
            else if (att_inc) att_cnt <= att_cnt + PW'(1);
            if (gap_clr)      gap_cnt <= '0;
            else if (gap_inc) gap_cnt <= gap_cnt + GW'(1);
        end
    end

endmodule
